// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM access arbiter.
// The arbiter shares one single-port DRAM between the instruction-fetch and data ports.
package dram_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned MASK_W     = WORD_BYTES;
endpackage

// File: rtl/dram_arb_pick.sv
// Combinational grant pick: MEM has priority unless IF has waited through
// STARVE_MAX back-to-back MEM grants.
module dram_arb_pick #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             i_if_req,
    input  logic             i_mem_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant_if,
    output logic             o_grant_mem
);
    logic w_if_forced;

    always_comb begin
        w_if_forced = (i_starve_cnt == CNT_W'(STARVE_MAX));
        o_grant_mem = i_mem_req && !(i_if_req && w_if_forced);
        o_grant_if  = i_if_req && !o_grant_mem;
    end
endmodule

// File: rtl/dram_access_arbiter.sv
// Arbitrates the single-port, variable-latency DRAM between the IF and MEM ports,
// with one outstanding access, starvation protection and a BUSY timeout.
module dram_access_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [MASK_W-1:0] mem_wmask,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic              err,
    output logic              dram_req,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic [MASK_W-1:0] dram_wmask,
    input  logic              dram_ack,
    input  logic [DATA_W-1:0] dram_rdata
);
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic [SC_W-1:0]   r_starve;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_if_done, r_mem_done, r_err;
    logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;
    logic              r_dram_req, r_dram_we;
    logic [ADDR_W-1:0] r_dram_addr;
    logic [DATA_W-1:0] r_dram_wdata;
    logic [MASK_W-1:0] r_dram_wmask;
    logic              w_grant_if, w_grant_mem;

    dram_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (SC_W)
    ) u_pick (
        .i_if_req     (if_req),
        .i_mem_req    (mem_req),
        .i_starve_cnt (r_starve),
        .o_grant_if   (w_grant_if),
        .o_grant_mem  (w_grant_mem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= OWN_IF;
            r_starve     <= '0;
            r_tmo        <= '0;
            r_if_done    <= 1'b0;
            r_mem_done   <= 1'b0;
            r_err        <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_dram_req   <= 1'b0;
            r_dram_we    <= 1'b0;
            r_dram_addr  <= '0;
            r_dram_wdata <= '0;
            r_dram_wmask <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (!if_req) r_starve <= '0;
                    r_tmo <= '0;
                    if (w_grant_if) begin
                        r_starve     <= '0;
                        r_owner      <= OWN_IF;
                        r_dram_req   <= 1'b1;
                        r_dram_we    <= 1'b0;
                        r_dram_addr  <= if_addr;
                        r_dram_wdata <= '0;
                        r_dram_wmask <= '0;
                        r_state      <= ARB_BUSY;
                    end else if (w_grant_mem) begin
                        if (if_req && r_starve != SC_W'(STARVE_MAX))
                            r_starve <= r_starve + 1'b1;
                        r_owner      <= OWN_MEM;
                        r_dram_req   <= 1'b1;
                        r_dram_we    <= mem_we;
                        r_dram_addr  <= mem_addr;
                        r_dram_wdata <= mem_wdata;
                        r_dram_wmask <= mem_wmask;
                        r_state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Done/err are raised here so they appear during the RESP cycle.
                    if (dram_ack) begin
                        r_dram_req <= 1'b0;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= dram_rdata;
                            r_if_done  <= 1'b1;
                        end else begin
                            if (!r_dram_we) r_mem_rdata <= dram_rdata;
                            r_mem_done <= 1'b1;
                        end
                        r_state <= ARB_RESP;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_dram_req <= 1'b0;
                        r_err      <= 1'b1;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= '0;
                            r_if_done  <= 1'b1;
                        end else begin
                            r_mem_rdata <= '0;
                            r_mem_done  <= 1'b1;
                        end
                        r_state <= ARB_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ARB_RESP: r_state <= ARB_IDLE;
                default:  r_state <= ARB_IDLE;
            endcase
        end
    end

    assign if_done    = r_if_done;
    assign if_rdata   = r_if_rdata;
    assign mem_done   = r_mem_done;
    assign mem_rdata  = r_mem_rdata;
    assign mem_stall  = mem_req & ~r_mem_done;
    assign err        = r_err;
    assign dram_req   = r_dram_req;
    assign dram_we    = r_dram_we;
    assign dram_addr  = r_dram_addr;
    assign dram_wdata = r_dram_wdata;
    assign dram_wmask = r_dram_wmask;
endmodule

// File: tb/tb_dram_access_arbiter.sv
// Randomized bench for dram_access_arbiter against a transaction-level reference
// model of the arbitration, latency, starvation and timeout rules.
module tb_dram_access_arbiter;
    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 8;
    localparam int unsigned NCYC = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wmask = '0;
    logic        mem_done;
    logic [63:0] mem_rdata;
    logic        mem_stall;
    logic        err;
    logic        dram_req;
    logic        dram_we;
    logic [63:0] dram_addr;
    logic [63:0] dram_wdata;
    logic [7:0]  dram_wmask;
    logic        dram_ack = 1'b0;
    logic [63:0] dram_rdata = '0;

    always #5 clk = ~clk;

    dram_access_arbiter #(
        .ADDR_W     (64),
        .DATA_W     (64),
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_done   (mem_done),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .err        (err),
        .dram_req   (dram_req),
        .dram_we    (dram_we),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_wmask (dram_wmask),
        .dram_ack   (dram_ack),
        .dram_rdata (dram_rdata)
    );

    // One in-flight DRAM access as the model sees it; lat > TMO-1 means never acked.
    typedef struct {
        bit          own_mem;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          age;
        int          lat;
    } acc_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    bit          has_acc;
    acc_t        acc;
    int          streak;
    bit          scripted;
    bit          e_if_done, e_mem_done, e_err;
    logic [63:0] e_if_rdata, e_mem_rdata;
    bit          e_dreq, e_dwe;
    logic [63:0] e_daddr, e_dwdata;
    logic [7:0]  e_dmask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        has_acc = 0; streak = 0; scripted = 0;
        e_if_done = 0; e_mem_done = 0; e_err = 0;
        e_if_rdata = '0; e_mem_rdata = '0;
        e_dreq = 0; e_dwe = 0; e_daddr = '0; e_dwdata = '0; e_dmask = '0;
    endtask

    task automatic finish_acc(input bit timed_out, input logic [63:0] rd);
        has_acc = 0;
        e_dreq = 0;
        e_err = timed_out;
        if (acc.own_mem) begin
            e_mem_done = 1;
            if (timed_out) e_mem_rdata = '0;
            else if (!acc.we) e_mem_rdata = rd;
        end else begin
            e_if_done = 1;
            e_if_rdata = timed_out ? 64'd0 : rd;
        end
        scripted = 0;
    endtask

    // Advance the model by one cycle given this cycle's inputs.
    task automatic model_step();
        bit idle_now;
        bit mem_wins;
        idle_now = !has_acc && !e_if_done && !e_mem_done;
        e_if_done = 0; e_mem_done = 0; e_err = 0;
        if (idle_now) begin
            mem_wins = mem_req && !(if_req && streak >= int'(SMAX));
            if (mem_wins) begin
                streak = if_req ? ((streak < int'(SMAX)) ? streak + 1 : int'(SMAX)) : 0;
                acc.own_mem = 1; acc.we = mem_we; acc.addr = mem_addr;
                acc.wdata = mem_wdata; acc.wmask = mem_wmask;
            end else begin
                streak = 0;
                acc.own_mem = 0; acc.we = 0; acc.addr = if_addr;
                acc.wdata = '0; acc.wmask = '0;
            end
            if (mem_wins || if_req) begin
                has_acc = 1;
                acc.age = 0;
                acc.lat = scripted ? 3 : int'($urandom_range(0, 9));
                e_dreq = 1; e_dwe = acc.we; e_daddr = acc.addr;
                e_dwdata = acc.wdata; e_dmask = acc.wmask;
            end
        end else if (has_acc) begin
            if (dram_ack) finish_acc(1'b0, dram_rdata);
            else if (acc.age == int'(TMO) - 1) finish_acc(1'b1, 64'd0);
            else acc.age++;
        end
    endtask

    task automatic check_all();
        check("dram_ctl", {55'd0, dram_req, dram_we, dram_wmask}, {55'd0, e_dreq, e_dwe, e_dmask});
        check("dram_addr", dram_addr, e_daddr);
        check("dram_wdata", dram_wdata, e_dwdata);
        check("pulses", {60'd0, if_done, mem_done, err, mem_stall},
              {60'd0, e_if_done, e_mem_done, e_err, mem_req & ~e_mem_done});
        check("if_rdata", if_rdata, e_if_rdata);
        check("mem_rdata", mem_rdata, e_mem_rdata);
    endtask

    initial begin
        bit          d_if, d_mem, did_reset, stray_next;
        int unsigned if_rate, mem_rate;
        model_reset();
        d_if = 0; d_mem = 0; did_reset = 0; stray_next = 0;
        @(posedge clk); #2;
        check_all();
        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk); #1;
            if (!did_reset && cyc >= 2600 && has_acc) begin
                did_reset = 1;
                reset = 0; if_req = 0; mem_req = 0; dram_ack = 0;
                #1;
                model_reset();
                check_all();
                d_if = 0; d_mem = 0; stray_next = 1;
                continue;
            end
            reset = 1;
            if (cyc < 12)        begin if_rate = 0;   mem_rate = 0;   end
            else if (cyc < 1500) begin if_rate = 30;  mem_rate = 40;  end
            else if (cyc < 2500) begin if_rate = 100; mem_rate = 100; end
            else                 begin if_rate = 60;  mem_rate = 60;  end
            if (cyc == 0) begin
                mem_req = 1; mem_we = 0; mem_addr = 64'h80; scripted = 1;
            end else if (!mem_req || d_mem) begin
                mem_req   = ($urandom_range(0, 99) < mem_rate);
                mem_we    = $urandom_range(0, 1) == 1;
                mem_addr  = {$urandom, $urandom} & ~64'h7;
                mem_wdata = {$urandom, $urandom};
                mem_wmask = 8'($urandom);
            end
            if (!if_req || d_if) begin
                if_req  = ($urandom_range(0, 99) < if_rate);
                if_addr = {$urandom, $urandom} & ~64'h7;
            end
            if (stray_next) begin
                if_req = 0; mem_req = 0;
            end
            dram_rdata = scripted ? 64'hDEAD_BEEF : {$urandom, $urandom};
            if (stray_next)   dram_ack = 1;
            else if (has_acc) dram_ack = (acc.age == acc.lat);
            else              dram_ack = ($urandom_range(0, 9) == 0);
            stray_next = 0;
            #1;
            check_all();
            d_if = e_if_done; d_mem = e_mem_done;
            model_step();
            if (n_bad > 40) break;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
